// File: rtl/bcd_seg_scanner_if.sv
// Display bus between a BCD digit source and the bcd_seg_scanner stage:
// packed digits and decimal points in, multiplexed segments and enables out.
interface bcd_seg_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    // Digit source side.
    modport master (
        output digits_in, dp_in,
        input  seg, dp, an, frame_done
    );

    // Scanner side.
    modport slave (
        input  digits_in, dp_in,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/bcd_seg_scanner.sv
// Time-multiplexed 7-segment scanner with a per-frame digit snapshot.
// Optional leading-zero blanking is enabled by defining BCD_SEG_LZB_EN.
module bcd_seg_scanner #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    bcd_seg_scanner_if.slave  bus
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

    // XOR masks turning active-high values into the selected drive polarity.
    localparam logic [6:0]            SEG_POL = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{SEG_ACTIVE_LOW}};

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [3:0]            shadow [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] shadow_dp;

    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic                  frame_done_q;

    logic                  tick;
    logic                  wrap;
    logic [NUM_DIGITS-1:0] an_hot;
    logic [NUM_DIGITS-1:0] blank;
    logic [6:0]            seg_next;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    assign tick = (presc == PRESC_MAX);
    assign wrap = (idx == IDX_MAX);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        an_hot      = '0;
        an_hot[idx] = 1'b1;
    end

`ifdef BCD_SEG_LZB_EN
    // A digit is blank when it and all higher digits are zero; digit 0 always shows.
    always_comb begin
        logic zero_run;
        blank    = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run && (shadow[k] == 4'd0);
            blank[k] = zero_run;
        end
    end
`else
    assign blank = '0;
`endif

    assign seg_next = blank[idx] ? 7'h00 : decode(shadow[idx]);

    // NOTE: sequential state uses non-blocking assignments only; the shadow is cleared
    // on reset so the first frame after reset shows zeros, not stale digits.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc        <= '0;
            idx          <= '0;
            shadow_dp    <= '0;
            for (int k = 0; k < NUM_DIGITS; k++) shadow[k] <= 4'd0;
            seg_q        <= SEG_POL;
            dp_q         <= SEG_ACTIVE_LOW;
            an_q         <= AN_POL;
            frame_done_q <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) idx <= wrap ? '0 : idx + 1'b1;

            // Snapshot only at the frame wrap so a frame never mixes old and new digits.
            frame_done_q <= tick && wrap;
            if (tick && wrap) begin
                for (int k = 0; k < NUM_DIGITS; k++) shadow[k] <= bus.digits_in[4*k +: 4];
                shadow_dp <= bus.dp_in;
            end

            seg_q <= seg_next ^ SEG_POL;
            dp_q  <= shadow_dp[idx] ^ SEG_ACTIVE_LOW;
            an_q  <= an_hot ^ AN_POL;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Self-checking bench for bcd_seg_scanner: directed vectors plus a per-cycle
// comparison against a frame/slot arithmetic model of the display.
module tb_bcd_seg_scanner;
    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int FRAME = N * DIV;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bcd_seg_scanner_if #(.NUM_DIGITS(N)) bus ();

    bcd_seg_scanner #(
        .NUM_DIGITS    (N),
        .REFRESH_DIV   (DIV),
        .SEG_ACTIVE_LOW(1'b0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Active-high segment table for codes 0..15.
    logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    // Model: n = clock edges since reset release. The slot shown after edge n+1
    // is digit (n / DIV) % N, taken from the snapshot made at the last multiple of FRAME.
    int              n;
    logic [4*N-1:0]  m_sh;
    logic [N-1:0]    m_dp;
    logic            m_valid = 1'b0;
    logic [6:0]      e_seg;
    logic [N-1:0]    e_an;
    logic            e_dp;
    logic            e_fd;

    always @(posedge clk) begin
        if (reset) begin
            n = 0; m_sh = '0; m_dp = '0;
            e_seg = 7'h00; e_an = '0; e_dp = 1'b0; e_fd = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            int k;
            logic [3:0] digit;
            k     = (n / DIV) % N;
            digit = 4'((m_sh >> (4 * k)) & 16'hF);
            e_seg = seg_tbl[digit];
`ifdef BCD_SEG_LZB_EN
            if (k > 0 && (m_sh >> (4 * k)) == 0) e_seg = 7'h00;
`endif
            e_an = N'(1 << k);
            e_dp = m_dp[k];
            n++;
            e_fd = (n % FRAME == 0);
            if (e_fd) begin
                m_sh = bus.digits_in;
                m_dp = bus.dp_in;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            check("cmp_seg", 32'(bus.seg), 32'(e_seg));
            check("cmp_an",  32'(bus.an),  32'(e_an));
            check("cmp_dp",  32'(bus.dp),  32'(e_dp));
            check("cmp_fd",  32'(bus.frame_done), 32'(e_fd));
        end
    end

    int t;
    task automatic advance_to(input int target);
        while (t < target) begin
            @(posedge clk);
            #1;
            t++;
        end
    endtask

`ifdef BCD_SEG_LZB_EN
    localparam logic [6:0] LZ = 7'h00;
`else
    localparam logic [6:0] LZ = 7'h3F;
`endif

    initial begin
        logic found;
        reset = 1'b1;
        bus.digits_in = '0;
        bus.dp_in = '0;
        t = 0;

        // Reset held three cycles: everything inactive.
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_seg", 32'(bus.seg), 32'h00);
            check("rst_an",  32'(bus.an),  32'h0);
            check("rst_fd",  32'(bus.frame_done), 32'h0);
        end
        reset = 1'b0;

        advance_to(1);
        check("first_an",  32'(bus.an),  32'h1);
        check("first_seg", 32'(bus.seg), 32'h3F);
        bus.digits_in = 16'h1234;
        bus.dp_in = 4'b0100;
        advance_to(5);  check("step_an1", 32'(bus.an), 32'h2);
        advance_to(9);  check("step_an2", 32'(bus.an), 32'h4);
        advance_to(13); check("step_an3", 32'(bus.an), 32'h8);
        check("step_seg3", 32'(bus.seg), 32'h3F);

        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            advance_to(t + 1);
            if (bus.frame_done) found = 1'b1;
        end
        check("fd_seen",  32'(found), 32'h1);
        check("fd_cycle", 32'(t), 32'd16);

        advance_to(17);
        check("f1_fd_pulse", 32'(bus.frame_done), 32'h0);
        check("f1_d0", 32'(bus.seg), 32'h66);
        advance_to(21); check("f1_d1", 32'(bus.seg), 32'h4F);
        bus.digits_in = 16'h9999;
        bus.dp_in = 4'b0000;
        advance_to(25);
        check("f1_d2", 32'(bus.seg), 32'h5B);
        check("f1_dp2", 32'(bus.dp), 32'h1);
        advance_to(29); check("f1_d3", 32'(bus.seg), 32'h06);
        advance_to(32); check("f2_fd", 32'(bus.frame_done), 32'h1);
        advance_to(33); check("f2_d0", 32'(bus.seg), 32'h6F);
        advance_to(37); check("f2_d1", 32'(bus.seg), 32'h6F);

        bus.digits_in = 16'h00A7;
        advance_to(49); check("a7_d0", 32'(bus.seg), 32'h07);
        advance_to(53); check("a7_d1", 32'(bus.seg), 32'h40);
        advance_to(57); check("a7_d2", 32'(bus.seg), 32'(LZ));
        advance_to(61); check("a7_d3", 32'(bus.seg), 32'(LZ));

        bus.digits_in = 16'h0000;
        advance_to(65); check("z_d0", 32'(bus.seg), 32'h3F);
        advance_to(69); check("z_d1", 32'(bus.seg), 32'(LZ));
        bus.digits_in = 16'h0105;
        advance_to(81); check("p_d0", 32'(bus.seg), 32'h6D);
        advance_to(85); check("p_d1", 32'(bus.seg), 32'h3F);
        advance_to(89); check("p_d2", 32'(bus.seg), 32'h06);
        advance_to(93); check("p_d3", 32'(bus.seg), 32'(LZ));

        // Reset mid-slot while digit 2 is enabled.
        advance_to(106);
        check("mid_an", 32'(bus.an), 32'h4);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_seg", 32'(bus.seg), 32'h00);
        check("mid_rst_an",  32'(bus.an),  32'h0);
        check("mid_rst_dp",  32'(bus.dp),  32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        t = 0;
        advance_to(1);
        check("restart_an",  32'(bus.an),  32'h1);
        check("restart_seg", 32'(bus.seg), 32'h3F);
        advance_to(9);
        check("restart_d2", 32'(bus.seg), 32'h3F);
        advance_to(17);
        check("restart_f1", 32'(bus.seg), 32'h6D);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
